// File: rtl/mips_pkg.sv
// ============================================================================
// Module  : mips_pkg
// Purpose : Shared decode/execute types: immediate extension mode encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  typedef logic [1:0] ext_mode_t;

  localparam ext_mode_t EXT_ZERO   = 2'b00;
  localparam ext_mode_t EXT_SIGN   = 2'b01;
  localparam ext_mode_t EXT_UPPER  = 2'b10;
  localparam ext_mode_t EXT_BRANCH = 2'b11;

endpackage

`default_nettype wire

// File: rtl/ext_fifo.sv
// ============================================================================
// Module  : ext_fifo
// Purpose : Generic WIDTH x DEPTH valid/ready FIFO with flush and a registered head.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ext_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    occupancy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] c_last_ptr = PW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_head;

  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_rd_nxt;
  logic [PW-1:0]    w_wr_nxt;
  logic [PW-1:0]    w_head_idx;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] w_head_src;

  assign in_ready  = (r_count < CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign out_data  = r_head;
  assign occupancy = r_count;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  // DEPTH may be any value, so wrap by compare rather than truncation
  assign w_rd_nxt = (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
  assign w_wr_nxt = (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Next head comes straight from the input when it lands in the head slot
  assign w_head_idx = w_pop ? w_rd_nxt : r_rd_ptr;
  assign w_head_src = (w_push && (w_head_idx == r_wr_ptr)) ? in_data : r_mem[w_head_idx];

  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= w_wr_nxt;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_nxt;
      end
      r_count <= w_count_nxt;
      if (w_count_nxt != '0) begin
        r_head <= w_head_src;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/imm_extend_stage.sv
// ============================================================================
// Module  : imm_extend_stage
// Purpose : Immediate extender (zero/sign/upper/branch) feeding a small valid/ready buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_extend_stage
  import mips_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_imm,
  input  ext_mode_t                  in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_imm,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int CW = $clog2(DEPTH + 1);

  generate
    if ((IN_W < 1) || (IN_W >= OUT_W - 1)) begin : g_bad_width
      $error("imm_extend_stage: IN_W must be in 1 .. OUT_W-2");
    end
    if ((DEPTH < 1) || (DEPTH > 8)) begin : g_bad_depth
      $error("imm_extend_stage: DEPTH must be in 1 .. 8");
    end
  endgenerate

  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_upper;
  logic [OUT_W-1:0] w_branch;
  logic [OUT_W-1:0] w_ext;

  assign w_zext   = {{(OUT_W-IN_W){1'b0}}, in_imm};
  assign w_sext   = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
  assign w_upper  = {in_imm, {(OUT_W-IN_W){1'b0}}};
  assign w_branch = {w_sext[OUT_W-3:0], 2'b00};

  always_comb begin
    w_ext = w_zext;
    case (in_mode)
      EXT_ZERO:   w_ext = w_zext;
      EXT_SIGN:   w_ext = w_sext;
      EXT_UPPER:  w_ext = w_upper;
      EXT_BRANCH: w_ext = w_branch;
      default:    w_ext = w_zext;
    endcase
  end

  ext_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_ext),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_imm),
    .occupancy (occupancy)
  );

endmodule

`default_nettype wire
